// File: rtl/blk_pixel_walker.sv
// blk_pixel_walker: expands one tetris block coordinate into the stream of
// every screen pixel it covers, scanning x fastest, one pixel per handshake.
module blk_pixel_walker #(
  parameter int BLK_SIZE = 24,
  parameter int X_BLKS   = 24,
  parameter int Y_BLKS   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [4:0] blk_x,
  input  logic [4:0] blk_y,
  output logic       px_valid,
  input  logic       px_ready,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic [4:0] px_off_x,
  output logic [4:0] px_off_y,
  output logic       px_last,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    BASE,
    EMIT
  } state_t;

  localparam logic [4:0] OffMax    = 5'(BLK_SIZE - 1);
  localparam logic [9:0] BlkSize10 = 10'(BLK_SIZE);
  localparam logic [5:0] XBlks6    = 6'(X_BLKS);
  localparam logic [5:0] YBlks6    = 6'(Y_BLKS);

  state_t     state_q;
  logic [4:0] blkX_q, blkY_q;
  logic [9:0] baseX_q, baseY_q;
  logic [9:0] pxX_q, pxY_q;
  logic [4:0] offX_q, offY_q;
  logic       pxValid_q, pxLast_q, err_q;

  logic [9:0] baseXCalc, baseYCalc;
  logic [4:0] offX_d, offY_d;
  logic       lastNext;
  logic       outOfRange;

  assign start_ready = (state_q == IDLE);
  assign px_valid    = pxValid_q;
  assign px_x        = pxX_q;
  assign px_y        = pxY_q;
  assign px_off_x    = offX_q;
  assign px_off_y    = offY_q;
  assign px_last     = pxLast_q;
  assign err         = err_q;

  assign outOfRange = ({1'b0, blk_x} >= XBlks6) || ({1'b0, blk_y} >= YBlks6);

  // Block origin in pixels: shift-add for the 24-pixel grid, plain constant multiply otherwise
  always_comb begin
    if (BLK_SIZE == 24) begin
      baseXCalc = ({5'b0, blkX_q} << 4) + ({5'b0, blkX_q} << 3);
      baseYCalc = ({5'b0, blkY_q} << 4) + ({5'b0, blkY_q} << 3);
    end else begin
      baseXCalc = {5'b0, blkX_q} * BlkSize10;
      baseYCalc = {5'b0, blkY_q} * BlkSize10;
    end
  end

  // Next offset in raster order: x wraps at the block edge and carries into y
  always_comb begin
    offX_d = offX_q;
    offY_d = offY_q;
    if (offX_q == OffMax) begin
      offX_d = '0;
      offY_d = offY_q + 5'd1;
    end else begin
      offX_d = offX_q + 5'd1;
    end
    lastNext = (offX_d == OffMax) && (offY_d == OffMax);
  end

  // Walker FSM with all pixel outputs registered; a stalled pixel simply holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      blkX_q    <= '0;
      blkY_q    <= '0;
      baseX_q   <= '0;
      baseY_q   <= '0;
      pxX_q     <= '0;
      pxY_q     <= '0;
      offX_q    <= '0;
      offY_q    <= '0;
      pxValid_q <= 1'b0;
      pxLast_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            blkX_q <= blk_x;
            blkY_q <= blk_y;
            if (outOfRange) begin
              err_q <= 1'b1;
            end else begin
              state_q <= BASE;
            end
          end
        end
        BASE: begin
          baseX_q   <= baseXCalc;
          baseY_q   <= baseYCalc;
          offX_q    <= '0;
          offY_q    <= '0;
          pxX_q     <= baseXCalc;
          pxY_q     <= baseYCalc;
          pxValid_q <= 1'b1;
          pxLast_q  <= (OffMax == 5'd0);
          state_q   <= EMIT;
        end
        EMIT: begin
          if (px_ready) begin
            if (pxLast_q) begin
              pxValid_q <= 1'b0;
              pxLast_q  <= 1'b0;
              state_q   <= IDLE;
            end else begin
              offX_q   <= offX_d;
              offY_q   <= offY_d;
              pxX_q    <= baseX_q + {5'b0, offX_d};
              pxY_q    <= baseY_q + {5'b0, offY_d};
              pxLast_q <= lastNext;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_pixel_walker.sv
// Testbench for blk_pixel_walker: drives block requests with random
// backpressure and compares every observed cycle to a raster-order model.
module tb_blk_pixel_walker;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic [4:0] blk_x;
  logic [4:0] blk_y;
  logic       px_valid;
  logic       px_ready;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic [4:0] px_off_x;
  logic [4:0] px_off_y;
  logic       px_last;
  logic       err;

  int checks   = 0;
  int failures = 0;

  blk_pixel_walker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_off_x   (px_off_x),
    .px_off_y   (px_off_y),
    .px_last    (px_last),
    .err        (err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Bundle of all observable outputs: {valid, start_ready, err, last, x, y, offx, offy}
  function automatic logic [35:0] observedVec();
    return {2'b00, px_valid, start_ready, err, px_last, px_x, px_y, px_off_x, px_off_y};
  endfunction

  // Expected outputs for the k-th pixel of block (bx, by) in raster order
  function automatic logic [35:0] expectedPixel(input int bx, input int by, input int k);
    int offX;
    int offY;
    offX = k % 24;
    offY = k / 24;
    return {2'b00, 1'b1, 1'b0, 1'b0, (k == 575), 10'(bx * 24 + offX), 10'(by * 24 + offY),
            5'(offX), 5'(offY)};
  endfunction

  localparam logic [35:0] IdleVec = {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 30'd0};

  // Issue one legal request and follow its walk; optionally reset after abortAfter transfers
  task automatic applyStimulus(input int bx, input int by, input bit stall, input int abortAfter);
    int  k;
    int  cycles;
    bit  rdy;
    checkOutput("readyBeforeReq", {35'd0, start_ready}, 36'd1);
    start_valid = 1'b1;
    blk_x       = 5'(bx);
    blk_y       = 5'(by);
    px_ready    = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    blk_x       = 5'($urandom);
    blk_y       = 5'($urandom);
    checkOutput("baseCycle", {33'd0, px_valid, start_ready, err}, 36'd0);
    @(negedge clk);
    k      = 0;
    cycles = 0;
    while (k < 576 && cycles < 5000) begin
      if (abortAfter >= 0 && k == abortAfter) begin
        rst_n = 1'b0;
        #1;
        checkOutput("resetMidWalk", observedVec(), IdleVec);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("afterAbortIdle", observedVec(), IdleVec);
        return;
      end
      checkOutput("pixel", observedVec(), expectedPixel(bx, by, k));
      rdy      = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      px_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      cycles++;
    end
    if (k < 576) checkOutput("walkTimeout", 36'(k), 36'd576);
    checkOutput("afterLast", {33'd0, px_valid, start_ready, err}, 36'b010);
  endtask

  // Issue an out-of-range request and confirm a single err pulse with no pixels
  task automatic applyBadRequest(input int bx, input int by);
    start_valid = 1'b1;
    blk_x       = 5'(bx);
    blk_y       = 5'(by);
    @(negedge clk);
    start_valid = 1'b0;
    checkOutput("errPulse", {33'd0, px_valid, start_ready, err}, 36'b011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("errQuiet", {33'd0, px_valid, start_ready, err}, 36'b010);
    end
  endtask

  // Main sequence
  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    blk_x       = '0;
    blk_y       = '0;
    px_ready    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("inReset", observedVec(), IdleVec);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleAfterReset", observedVec(), IdleVec);

    applyStimulus(0, 0, 1'b0, -1);
    applyStimulus(23, 19, 1'b0, -1);
    applyStimulus(5, 2, 1'b1, -1);
    applyBadRequest(24, 0);
    applyBadRequest(0, 20);
    applyBadRequest(31, 31);
    applyStimulus(7, 4, 1'b0, 100);
    applyStimulus(3, 3, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      applyStimulus($urandom_range(0, 23), $urandom_range(0, 19), 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blk_pixel_walker.md
Name: blk_pixel_walker

Overview:
- Inverse of the pixel-to-block mapping: takes a block coordinate (blk_x, blk_y) on the 24-pixel tetris grid and emits, one per handshake, every pixel coordinate covered by that block.
- For each pixel it emits the screen position and the in-block offsets.
- Sits between the playfield/sprite logic (issuing block draw requests) and the framebuffer write port, which consumes pixels through a valid/ready stream.

Parameters:
- BLK_SIZE, 24, block edge in pixels; base computed as blk*BLK_SIZE.
- X_BLKS, 24, number of valid horizontal blocks (0..X_BLKS-1).
- Y_BLKS, 20, number of valid vertical blocks (0..Y_BLKS-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  block draw request valid.
- start_ready  out  1  walker idle, request accepted on start_valid&&start_ready.
- blk_x  in  5  horizontal block index, sampled on accept.
- blk_y  in  5  vertical block index, sampled on accept.
- px_valid  out  1  pixel output valid.
- px_ready  in  1  downstream accepts pixel.
- px_x  out  10  screen x = blk_x*BLK_SIZE + off_x.
- px_y  out  10  screen y = blk_y*BLK_SIZE + off_y.
- px_off_x  out  5  offset within block, 0..BLK_SIZE-1.
- px_off_y  out  5  offset within block, 0..BLK_SIZE-1.
- px_last  out  1  high with final pixel (off_x=off_y=BLK_SIZE-1).
- err  out  1  one-cycle pulse: accepted request out of range.

Behaviour:
- Reset (rst_n=0, async):
  - State is IDLE.
  - px_valid, px_last and err are 0.
  - px_x, px_y, px_off_x and px_off_y are 0.
  - Internal base registers are 0.
- start_ready = (state==IDLE). It is 1 out of reset, but no request is accepted while rst_n is low.
- States:
  - IDLE:
    - On start_valid && start_ready, latch blk_x and blk_y.
    - If blk_x>=X_BLKS or blk_y>=Y_BLKS, pulse err for 1 cycle (the cycle after accept), stay IDLE, emit no pixels.
    - Otherwise go to BASE.
  - BASE (1 cycle):
    - base_x = (blk_x<<4)+(blk_x<<3); base_y likewise (shift-add for BLK_SIZE=24; generic multiply-by-constant otherwise).
    - Offsets are cleared.
    - Go to EMIT.
  - EMIT:
    - px_valid=1 and outputs are registered.
    - Accept cycle N gives first px_valid at N+2.
- Handshake:
  - A transfer happens when px_valid && px_ready.
  - While px_valid && !px_ready, all px_* outputs are held stable.
  - A new pixel may follow every cycle (full throughput, no bubbles) while px_ready=1.
- Scan order:
  - off_x increments fastest, 0..BLK_SIZE-1.
  - On off_x wrap, off_x returns to 0 and off_y increments.
- Last pixel:
  - px_last=1 only when off_x=off_y=BLK_SIZE-1.
  - On its transfer, px_valid drops next cycle and the state returns to IDLE, so start_ready=1 the cycle after the last transfer.
  - The total is exactly BLK_SIZE*BLK_SIZE (576) transfers per request.
- Widths:
  - px_x max = 23*24+23 = 575 and px_y max = 19*24+23 = 479. Both fit in 10 bits; no overflow possible for legal parameters.
- blk_x and blk_y changes while not in IDLE are ignored (values are latched at accept).
- Reset asserted mid-EMIT: outputs clear immediately (asynchronously), the walk is abandoned, and there is no resume after release.

Test Plan:
- Reset, then idle: release rst_n with start_valid=0 -> start_ready=1; px_valid=0; err=0; all px_* = 0.
- Basic walk, blk_x=0, blk_y=0, px_ready=1 -> 576 transfers starting 2 cycles after accept:
  - first pixel (0,0);
  - 25th pixel (0,1) with off_x=0, off_y=1;
  - last pixel (23,23) with px_last=1;
  - start_ready=1 next cycle.
- Far corner, blk_x=23, blk_y=19 -> first pixel px_x=552, px_y=456; last pixel px_x=575, px_y=479 with px_last.
- Backpressure, blk_x=5, blk_y=2: toggle px_ready randomly -> outputs stable while stalled; sequence identical to the no-stall run (px_x 120..143, px_y 48..71); exactly 576 transfers.
- Out of range: blk_x=24 -> err=1 for exactly one cycle; px_valid never asserts; start_ready stays 1. Repeat the check with blk_y=20.
- Reset mid-walk: assert rst_n low after 100 transfers -> px_valid drops immediately; after release a new request (3,3) walks from (72,72) cleanly.
